// File: rtl/shift_unit_pipe.sv
// Two-stage pipelined shift/rotate unit (SHL/SHR/SAR) with x86 flag generation.
// Define SHIFT_ROTATE_EN to add ROL/ROR; otherwise those opcodes are illegal.
module shift_unit_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [1:0]       in_size,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [5:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [5:0]       out_flags,
  output logic             out_flags_we
);

  typedef enum logic [2:0] {
    OP_SHL = 3'b000,
    OP_SHR = 3'b001,
    OP_SAR = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    SZ_8   = 2'b00,
    SZ_16  = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } size_e;

  function automatic logic [WIDTH-1:0] size_mask(input size_e sz);
    case (sz)
      SZ_8:    return {{(WIDTH-8){1'b0}}, 8'hFF};
      SZ_16:   return {{(WIDTH-16){1'b0}}, 16'hFFFF};
      SZ_W:    return '1;
      default: return '0;
    endcase
  endfunction

  logic             s1_valid, s2_valid, s1_adv, s2_adv;
  op_e              s1_op;
  size_e            s1_size;
  logic [WIDTH-1:0] s1_data;
  logic [CNT_W-1:0] s1_cnt;
  logic [5:0]       s1_flags;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_SHL;
      s1_size  <= SZ_8;
      s1_data  <= '0;
      s1_cnt   <= '0;
      s1_flags <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op    <= op_e'(in_op);
        s1_size  <= size_e'(in_size);
        s1_data  <= in_data & size_mask(size_e'(in_size));
        s1_cnt   <= in_cnt;
        s1_flags <= in_flags;
      end
    end
  end

  logic [WIDTH-1:0] mask, msb, x, sext, res_d;
  logic [WIDTH:0]   shl_v, shr_v;
  logic             sign, fill, shl_cf, one, legal, cf, of, we_d;
  logic [5:0]       flags_d;
`ifdef SHIFT_ROTATE_EN
  logic [WIDTH-1:0] rep, rol_v, ror_v;
`endif

  always_comb begin
    mask  = size_mask(s1_size);
    msb   = mask ^ (mask >> 1);
    x     = s1_data;
    sign  = |(x & msb);
    fill  = (s1_op == OP_SAR) && sign;
    sext  = x | (fill ? ~mask : '0);
    // Extra LSB on the right shifter / bit S on the left shifter hold the last bit shifted out.
    shl_v = {1'b0, x};
    shr_v = {sext, 1'b0};
    for (int unsigned k = 0; k < CNT_W; k++) begin
      if (s1_cnt[k]) begin
        shl_v = shl_v << (2**k);
        shr_v = (shr_v >> (2**k)) | (fill ? ~({(WIDTH+1){1'b1}} >> (2**k)) : '0);
      end
    end
    case (s1_size)
      SZ_8:    shl_cf = shl_v[8];
      SZ_16:   shl_cf = shl_v[16];
      default: shl_cf = shl_v[WIDTH];
    endcase
`ifdef SHIFT_ROTATE_EN
    // Replicating the operand across WIDTH makes a WIDTH-bit rotate equal a rotate mod S.
    case (s1_size)
      SZ_8:    rep = {(WIDTH/8){x[7:0]}};
      SZ_16:   rep = {(WIDTH/16){x[15:0]}};
      default: rep = x;
    endcase
    rol_v = rep;
    ror_v = rep;
    for (int unsigned k = 0; k < CNT_W; k++) begin
      if (s1_cnt[k]) begin
        rol_v = (rol_v << (2**k)) | (rol_v >> (WIDTH - 2**k));
        ror_v = (ror_v >> (2**k)) | (ror_v << (WIDTH - 2**k));
      end
    end
    legal = (s1_size != SZ_BAD) && (s1_op inside {OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR});
`else
    legal = (s1_size != SZ_BAD) && (s1_op inside {OP_SHL, OP_SHR, OP_SAR});
`endif
    one     = (s1_cnt == CNT_W'(1));
    res_d   = '0;
    flags_d = s1_flags;
    we_d    = 1'b0;
    cf      = 1'b0;
    of      = 1'b0;
    if (legal && s1_cnt == '0) begin
      res_d = x;
    end else if (legal) begin
      we_d = 1'b1;
      case (s1_op)
        OP_SHL: begin
          res_d = shl_v[WIDTH-1:0] & mask;
          cf    = shl_cf;
          of    = one && (|(res_d & msb) ^ cf);
        end
        OP_SHR: begin
          res_d = shr_v[WIDTH:1] & mask;
          cf    = shr_v[0];
          of    = one && sign;
        end
        OP_SAR: begin
          res_d = shr_v[WIDTH:1] & mask;
          cf    = shr_v[0];
        end
`ifdef SHIFT_ROTATE_EN
        OP_ROL: begin
          res_d = rol_v & mask;
          cf    = res_d[0];
          of    = one && (|(res_d & msb) ^ cf);
        end
        OP_ROR: begin
          res_d = ror_v & mask;
          cf    = |(res_d & msb);
          of    = one && (cf ^ |(res_d & (msb >> 1)));
        end
`endif
        default: ;
      endcase
      if (s1_op inside {OP_SHL, OP_SHR, OP_SAR})
        flags_d = {of, |(res_d & msb), res_d == '0, 1'b0, ~^res_d[7:0], cf};
      else
        flags_d = {of, s1_flags[4:1], cf};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid     <= 1'b0;
      out_data     <= '0;
      out_flags    <= '0;
      out_flags_we <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= res_d;
        out_flags    <= flags_d;
        out_flags_we <= we_d;
      end
    end
  end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe; expected results come from a bit-serial reference model.
module tb_shift_unit_pipe;
  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] data;
    logic [5:0]   flags;
    logic         we;
  } res_t;

  logic         clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic         in_ready, out_valid, out_flags_we;
  logic [2:0]   in_op = '0;
  logic [1:0]   in_size = '0;
  logic [W-1:0] in_data = '0;
  logic [4:0]   in_cnt = '0;
  logic [5:0]   in_flags = '0;
  logic [W-1:0] out_data;
  logic [5:0]   out_flags;

  int   passed = 0, total = 0;
  bit   rand_bp = 1'b0;
  res_t sb[$];

  shift_unit_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_size(in_size), .in_data(in_data), .in_cnt(in_cnt), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags), .out_flags_we(out_flags_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic res_t model(input logic [2:0] op, input logic [1:0] size, input logic [W-1:0] d,
                                 input logic [4:0] cnt, input logic [5:0] fl);
    res_t r;
    int unsigned s;
    logic [W-1:0] m, v;
    logic cf, of, top;
    bit rot_ok;
`ifdef SHIFT_ROTATE_EN
    rot_ok = 1'b1;
`else
    rot_ok = 1'b0;
`endif
    r.data = '0; r.flags = fl; r.we = 1'b0;
    case (size)
      2'd0: s = 8;
      2'd1: s = 16;
      2'd2: s = W;
      default: s = 0;
    endcase
    if (s == 0 || op > 3'd4 || (op > 3'd2 && !rot_ok)) return r;
    m = (s == W) ? '1 : ((W'(1) << s) - W'(1));
    v = d & m;
    if (cnt == 0) begin
      r.data = v;
      return r;
    end
    cf = 1'b0;
    for (int unsigned i = 0; i < cnt; i++) begin
      case (op)
        3'd0: begin cf = v[s-1]; v = (v << 1) & m; end
        3'd1: begin cf = v[0]; v = v >> 1; end
        3'd2: begin cf = v[0]; top = v[s-1]; v = (v >> 1) | ({{(W-1){1'b0}}, top} << (s-1)); end
        3'd3: begin top = v[s-1]; v = ((v << 1) & m) | {{(W-1){1'b0}}, top}; end
        default: begin top = v[0]; v = (v >> 1) | ({{(W-1){1'b0}}, top} << (s-1)); end
      endcase
    end
    r.data = v;
    r.we = 1'b1;
    of = 1'b0;
    if (op <= 3'd2) begin
      if (cnt == 1) of = (op == 3'd0) ? (v[s-1] ^ cf) : (op == 3'd1) ? d[s-1] : 1'b0;
      r.flags = {of, v[s-1], v == '0, 1'b0, ~^v[7:0], cf};
    end else begin
      cf = (op == 3'd3) ? v[0] : v[s-1];
      if (cnt == 1) of = (op == 3'd3) ? (v[s-1] ^ cf) : (v[s-1] ^ v[s-2]);
      r.flags = {of, fl[4:1], cf};
    end
    return r;
  endfunction

  // Outputs are inspected mid-cycle; a stalled result is compared against the queue head too.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {63'b0, out_valid}, 64'd0);
      end else begin
        chk(out_ready ? "out_data" : "hold_data", out_data, sb[0].data);
        chk(out_ready ? "out_flags" : "hold_flags", out_flags, sb[0].flags);
        chk(out_ready ? "out_we" : "hold_we", out_flags_we, sb[0].we);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [W-1:0] d,
                      input logic [4:0] c, input logic [5:0] f);
    bit acc = 1'b0;
    in_op = op; in_size = sz; in_data = d; in_cnt = c; in_flags = f; in_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        acc = 1'b1;
        sb.push_back(model(op, sz, d, c, f));
      end
      @(posedge clk); #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    chk("send_accept", {63'b0, acc}, 64'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", sb.size(), 64'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, out_valid, 64'd0);
    chk({tag, "_data"}, out_data, 64'd0);
    chk({tag, "_flags"}, out_flags, 64'd0);
    chk({tag, "_we"}, out_flags_we, 64'd0);
    chk({tag, "_ready"}, in_ready, 64'd1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 chk_idle("reset");
    @(posedge clk); #1 rst = 1'b0;

    // First transaction: latency and directed values
    send(3'd2, 2'd0, 32'h80, 5'd1, 6'd0);
    chk("lat_cycle1", out_valid, 64'd0);
    @(posedge clk); #1;
    chk("lat_cycle2", out_valid, 64'd1);
    chk("sar8_data", out_data, 64'h0000_00C0);
    chk("sar8_flags", out_flags, 64'b010010);
    chk("sar8_we", out_flags_we, 64'd1);
    drain();

    send(3'd1, 2'd2, 32'h0000_0001, 5'd1, 6'd0);
    send(3'd0, 2'd1, 32'h0000_8000, 5'd1, 6'd0);
    send(3'd0, 2'd2, 32'h1234_5678, 5'd0, 6'b101011);
    send(3'd3, 2'd0, 32'h0000_0081, 5'd1, 6'b011110);
    send(3'd4, 2'd1, 32'h0000_0001, 5'd17, 6'd0);
    send(3'd1, 2'd3, 32'hDEAD_BEEF, 5'd3, 6'b110101);
    send(3'd7, 2'd2, 32'hDEAD_BEEF, 5'd3, 6'b001100);
    send(3'd0, 2'd0, 32'h0000_0001, 5'd8, 6'd0);
    send(3'd2, 2'd0, 32'h0000_0080, 5'd9, 6'd0);
    send(3'd1, 2'd1, 32'hFFFF_8000, 5'd16, 6'd0);
    send(3'd1, 2'd0, 32'h0000_00FF, 5'd20, 6'd0);
    send(3'd2, 2'd2, 32'h8000_0000, 5'd31, 6'd0);
    drain();

    // Backpressure: two accepted, then in_ready must drop until out_ready returns
    out_ready = 1'b0;
    send(3'd0, 2'd2, 32'h0000_0011, 5'd2, 6'd0);
    send(3'd1, 2'd2, 32'h0000_2200, 5'd3, 6'd0);
    in_op = 3'd2; in_size = 2'd1; in_data = 32'h0000_8330; in_cnt = 5'd4; in_flags = 6'd0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(3'd2, 2'd1, 32'h0000_8330, 5'd4, 6'd0);
    send(3'd0, 2'd0, 32'h0000_0044, 5'd5, 6'd0);
    drain();

    // Flush with both stages full and a new op offered
    out_ready = 1'b0;
    send(3'd0, 2'd2, 32'h0000_0101, 5'd1, 6'd0);
    send(3'd1, 2'd2, 32'h0000_0202, 5'd1, 6'd0);
    in_op = 3'd0; in_size = 2'd2; in_data = 32'h0000_0303; in_cnt = 5'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 64'd0);
    chk("flush_ready", in_ready, 64'd1);
    sb.delete();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("flush_idle", out_valid, 64'd0);

    // Asynchronous reset mid-stream
    send(3'd0, 2'd2, 32'h0000_0505, 5'd2, 6'd0);
    send(3'd1, 2'd2, 32'h0000_0606, 5'd2, 6'd0);
    @(posedge clk); #3 rst = 1'b1;
    #1 chk_idle("midrst");
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 chk("post_rst_valid", out_valid, 64'd0);

    // Random operations under random output backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++)
      send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom,
           5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)));
    rand_bp = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
